membus_avalon_master: RTL and testbench
=======================================

Name: membus_avalon_master

Overview:
- Initiator-side bridge between the PDP-6 processor memory bus and a 36-bit Avalon-MM word slave, such as the 16K on-chip core.
- Converts a membus cycle into one Avalon read and/or write. Cycle types: read, write, or read-modify-write.
- Returns address-acknowledge, read-restart and read data to the processor.
- Sits between the CPU bus logic and the memory slaves; one instance per memory port.

Parameters:
- MEM_BASE, 18'o000000, first membus address served.
- MEM_WORDS, 16384, number of words served; addresses in [MEM_BASE, MEM_BASE+MEM_WORDS) are accepted.
- TIMEOUT, 255, max cycles of continuous i_waitrequest before the cycle is abandoned.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-high reset
- i_membus_rq_cyc  in  1  processor requests a memory cycle (level, held for the whole cycle)
- i_membus_rd_rq  in  1  read requested (level, valid with rq_cyc)
- i_membus_wr_rq  in  1  write requested (level, valid with rq_cyc)
- i_membus_ma  in  18  word address
- i_membus_wr_rs  in  1  write restart: write data valid (one-cycle pulse)
- i_membus_mb_in  in  36  write data, sampled on wr_rs
- o_membus_addr_ack  out  1  address acknowledge (one-cycle pulse)
- o_membus_rd_rs  out  1  read restart: read data valid (one-cycle pulse)
- o_membus_mb_out  out  36  read data, held until the next read completes
- o_address  out  18  Avalon word address = ma - MEM_BASE
- o_read  out  1  Avalon read
- o_write  out  1  Avalon write
- o_writedata  out  36  Avalon write data
- i_readdata  in  36  Avalon read data
- i_waitrequest  in  1  Avalon wait
- o_timeout  out  1  sticky: an Avalon access was abandoned; cleared only by reset

Behaviour:
- Reset (async, i_reset=1): all outputs 0, state IDLE, timeout counter 0.
- Start condition: a cycle starts only on a rising edge of rq_cyc, detected with a registered copy of rq_cyc, and only in IDLE.
  - Address outside the window: no response, go to DONE. The processor times out on nonexistent memory.
  - rd_rq=0 and wr_rq=0: treated the same as out of range.
- Address capture: ma is latched at start into o_address (minus MEM_BASE); o_address holds until the next start.
- States:
  - IDLE
  - RD: o_read=1 until the first cycle with i_waitrequest=0. In that cycle i_readdata is latched into mb_out; next state is RDACK.
  - RDACK: one cycle; addr_ack=1 and rd_rs=1.
    - If wr_rq: next state WWAIT (read-modify-write). Else: next state DONE.
  - WACK: write-only start goes here; one cycle; addr_ack=1; next state WWAIT.
  - WWAIT: wait for wr_rs.
    - On wr_rs: latch mb_in into o_writedata; next state WR.
    - If rq_cyc drops first: next state IDLE with no write.
  - WR: o_write=1 until the first cycle with i_waitrequest=0; next state DONE.
  - DONE: wait for rq_cyc=0, then IDLE.
- Latency against a slave with 1-cycle wait, counted from the rising edge of rq_cyc:
  - read: o_read at +1, data latched at +2, addr_ack/rd_rs at +3.
  - write: addr_ack at +1, then o_write asserted the cycle after wr_rs.
- Avalon rules: o_read and o_write are never both 1. Address and data are stable while waitrequest=1.
- Timeout:
  - An 8-bit counter increments each RD/WR cycle with waitrequest=1 and clears on state change.
  - Reaching TIMEOUT: deassert read/write, set o_timeout, go to DONE. No rd_rs; no ack if not yet sent.
- Pulse rules: addr_ack and rd_rs are exactly one cycle wide, at most one each per cycle.
- Robustness:
  - A wr_rs outside WWAIT is ignored.
  - rq_cyc dropping during RD/WR does not abort the Avalon access, because Avalon needs completion. Finish it, suppress the pending pulses, go to IDLE.
- Address arithmetic: 18-bit subtraction; the range check uses (ma - MEM_BASE) < MEM_WORDS, computed unsigned at 19 bits.

Decomposition:
- Shared package membus_pkg:
  - state encoding (IDLE, RD, RDACK, WACK, WWAIT, WR, DONE)
  - word width 36
  - address width 18
  - default window constants
- Sub-module: edge_detect (registered rising-edge detector) for rq_cyc. It will be reused by other membus ports.

Test Plan:
- Read, slave returns 36'o123456701234 with 1 wait cycle, ma=18'o000100 -> o_address=100, o_read for 2 cycles, addr_ack and rd_rs together at +3, mb_out=123456701234.
- Write ma=18'o037777, wr_rs with mb_in=36'o777777777777 -> addr_ack at +1, o_write one cycle after wr_rs, writedata=777777777777, then DONE until rq_cyc falls.
- Read-modify-write at 18'o000005 -> read, addr_ack+rd_rs, then write after wr_rs; exactly one o_read and one o_write handshake.
- ma=18'o040000 with MEM_WORDS=16384 -> no o_read/o_write, no ack ever; IDLE after rq_cyc drops.
- Waitrequest stuck high on read, TIMEOUT=255 -> o_read dropped after 255 cycles, o_timeout=1, no rd_rs.
- Reset asserted mid-WR -> all outputs 0 immediately (async); the next rq_cyc rising edge starts a clean cycle.

Source files
------------

// File: rtl/membus_pkg.sv
// membus_pkg: shared membus types, widths and default memory window
package membus_pkg;
  localparam int WORD_W = 36;
  localparam int ADDR_W = 18;
  localparam logic [ADDR_W-1:0] DEF_MEM_BASE = 18'o000000;
  localparam int DEF_MEM_WORDS = 16384;
  localparam int DEF_TIMEOUT = 255;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_RDACK, S_WACK, S_WWAIT, S_WR, S_DONE} state_t;
  function automatic logic in_window(input logic [ADDR_W-1:0] ma, input logic [ADDR_W-1:0] base, input int words);
    logic [ADDR_W:0] off;
    logic [ADDR_W:0] lim;
    off = {1'b0, ma} - {1'b0, base};
    lim = words[ADDR_W:0];
    return off < lim;
  endfunction
endpackage

// File: rtl/edge_detect.sv
// edge_detect: registered rising-edge detector for a level request line
module edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_rise
);
  logic r_prev;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_prev <= 1'b0;
    else r_prev <= i_sig;
  assign o_rise = i_sig & ~r_prev;
endmodule

// File: rtl/membus_avalon_master.sv
// membus_avalon_master: PDP-6 membus cycle to Avalon-MM read/write bridge
module membus_avalon_master
  import membus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MEM_BASE = DEF_MEM_BASE,
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int TIMEOUT = DEF_TIMEOUT
)(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_membus_rq_cyc,
  input  logic              i_membus_rd_rq,
  input  logic              i_membus_wr_rq,
  input  logic [ADDR_W-1:0] i_membus_ma,
  input  logic              i_membus_wr_rs,
  input  logic [WORD_W-1:0] i_membus_mb_in,
  output logic              o_membus_addr_ack,
  output logic              o_membus_rd_rs,
  output logic [WORD_W-1:0] o_membus_mb_out,
  output logic [ADDR_W-1:0] o_address,
  output logic              o_read,
  output logic              o_write,
  output logic [WORD_W-1:0] o_writedata,
  input  logic [WORD_W-1:0] i_readdata,
  input  logic              i_waitrequest,
  output logic              o_timeout
);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  state_t r_state;
  state_t w_next;
  logic [7:0] r_cnt;
  logic w_rise;
  logic w_start;
  logic w_ok;
  logic w_busy;
  logic w_done;
  logic w_tmo;
  edge_detect u_rq_edge (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_sig  (i_membus_rq_cyc),
    .o_rise (w_rise)
  );
  always_comb begin
    w_start = (r_state == S_IDLE) && w_rise;
    w_ok = (i_membus_rd_rq | i_membus_wr_rq) && in_window(i_membus_ma, MEM_BASE, MEM_WORDS);
    w_busy = (r_state == S_RD) || (r_state == S_WR);
    w_done = w_busy && !i_waitrequest;
    w_tmo = w_busy && i_waitrequest && (r_cnt == TMO_LAST);
    w_next = r_state;
    // a dropped rq_cyc never aborts an Avalon access; it only skips the pulses afterwards
    case (r_state)
      S_IDLE:  w_next = !w_start ? S_IDLE : !w_ok ? S_DONE : i_membus_rd_rq ? S_RD : S_WACK;
      S_RD:    w_next = w_tmo ? S_DONE : !w_done ? S_RD : i_membus_rq_cyc ? S_RDACK : S_IDLE;
      S_RDACK: w_next = i_membus_wr_rq ? S_WWAIT : S_DONE;
      S_WACK:  w_next = S_WWAIT;
      S_WWAIT: w_next = !i_membus_rq_cyc ? S_IDLE : i_membus_wr_rs ? S_WR : S_WWAIT;
      S_WR:    w_next = w_tmo ? S_DONE : !w_done ? S_WR : i_membus_rq_cyc ? S_DONE : S_IDLE;
      S_DONE:  w_next = i_membus_rq_cyc ? S_DONE : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt <= 8'd0;
      o_address <= '0;
      o_membus_mb_out <= '0;
      o_writedata <= '0;
      o_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= (w_busy && i_waitrequest && !w_tmo) ? r_cnt + 8'd1 : 8'd0;
      o_timeout <= o_timeout | w_tmo;
      if (w_start) o_address <= i_membus_ma - MEM_BASE;
      if ((r_state == S_RD) && w_done && i_membus_rq_cyc) o_membus_mb_out <= i_readdata;
      if ((r_state == S_WWAIT) && i_membus_rq_cyc && i_membus_wr_rs) o_writedata <= i_membus_mb_in;
    end
  assign o_read = r_state == S_RD;
  assign o_write = r_state == S_WR;
  assign o_membus_addr_ack = (r_state == S_RDACK) || (r_state == S_WACK);
  assign o_membus_rd_rs = r_state == S_RDACK;
endmodule

// File: tb/tb_membus_avalon_master.sv
// tb_membus_avalon_master: randomized scoreboard bench against a memory reference model
module tb_membus_avalon_master;
  localparam int WORDS = 16384;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_membus_rq_cyc = 1'b0;
  logic i_membus_rd_rq = 1'b0;
  logic i_membus_wr_rq = 1'b0;
  logic [17:0] i_membus_ma = '0;
  logic i_membus_wr_rs = 1'b0;
  logic [35:0] i_membus_mb_in = '0;
  logic o_membus_addr_ack, o_membus_rd_rs, o_read, o_write, o_timeout;
  logic [35:0] o_membus_mb_out, o_writedata;
  logic [17:0] o_address;
  logic [35:0] i_readdata = '0;
  logic i_waitrequest = 1'b0;
  int checks = 0;
  int failures = 0;
  int mode = 0;
  int wcnt = 0;
  logic [35:0] slave_mem[WORDS];
  logic [35:0] ref_mem[WORDS];
  logic [17:0] exp_raddr[$];
  logic [35:0] exp_rdata[$];
  logic [53:0] exp_w[$];
  logic prev_ack = 1'b0;
  logic prev_rs = 1'b0;
  logic prev_busy = 1'b0;
  logic [17:0] prev_addr = '0;

  always #5 clk = ~clk;

  membus_avalon_master dut (
    .i_clk(clk), .i_reset(reset),
    .i_membus_rq_cyc(i_membus_rq_cyc), .i_membus_rd_rq(i_membus_rd_rq), .i_membus_wr_rq(i_membus_wr_rq),
    .i_membus_ma(i_membus_ma), .i_membus_wr_rs(i_membus_wr_rs), .i_membus_mb_in(i_membus_mb_in),
    .o_membus_addr_ack(o_membus_addr_ack), .o_membus_rd_rs(o_membus_rd_rs), .o_membus_mb_out(o_membus_mb_out),
    .o_address(o_address), .o_read(o_read), .o_write(o_write), .o_writedata(o_writedata),
    .i_readdata(i_readdata), .i_waitrequest(i_waitrequest), .o_timeout(o_timeout)
  );

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0o required=%0o t=%0t", nm, act, exp, $time);
    end
  endtask

  // Avalon slave: mode 0 random waits, 1 exactly one wait per access, 2 waitrequest stuck high
  always @(posedge clk) begin
    #1;
    if (o_read | o_write) begin
      i_waitrequest = (mode == 2) ? 1'b1 : (mode == 1) ? (wcnt == 0) : ($urandom_range(0, 3) == 0);
      wcnt++;
    end else begin
      wcnt = 0;
      i_waitrequest = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    i_readdata = slave_mem[o_address[13:0]];
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      prev_ack = 1'b0;
      prev_rs = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (o_read | o_write) chk("rd_wr_exclusive", o_read & o_write, 0);
      if (prev_busy && (o_read | o_write)) chk("addr_stable", o_address, prev_addr);
      prev_busy = (o_read | o_write) && i_waitrequest;
      prev_addr = o_address;
      if (o_read && !i_waitrequest) begin
        chk("read_expected", exp_raddr.size() != 0, 1);
        if (exp_raddr.size() != 0) chk("read_addr", o_address, exp_raddr.pop_front());
      end
      if (o_write && !i_waitrequest) begin
        slave_mem[o_address[13:0]] = o_writedata;
        chk("write_expected", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) chk("write_addr_data", {o_address, o_writedata}, exp_w.pop_front());
      end
      if (o_membus_rd_rs) begin
        chk("rs_with_ack", o_membus_addr_ack, 1);
        chk("rdata_expected", exp_rdata.size() != 0, 1);
        if (exp_rdata.size() != 0) chk("read_data", o_membus_mb_out, exp_rdata.pop_front());
      end
      if (o_membus_addr_ack) chk("ack_one_cycle", prev_ack, 0);
      if (o_membus_rd_rs) chk("rs_one_cycle", prev_rs, 0);
      prev_ack = o_membus_addr_ack;
      prev_rs = o_membus_rd_rs;
    end
  end

  task automatic wait_out(input bit wr_hs, input string nm);
    bit got = 0;
    for (int i = 0; i < 1000; i++) begin
      if (wr_hs ? (o_write && !i_waitrequest) : o_membus_addr_ack) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk(nm, got, 1);
  endtask

  task automatic drop_rq();
    i_membus_rq_cyc = 1'b0;
    i_membus_rd_rq = 1'b0;
    i_membus_wr_rq = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input bit rd, input bit wr, input logic [17:0] ma, input logic [35:0] wd, input bit abort);
    int a = int'(ma);
    bit live = (rd || wr) && (a < WORDS);
    if (live && rd) begin
      exp_raddr.push_back(ma);
      exp_rdata.push_back(ref_mem[a]);
    end
    if (live && wr && !abort) begin
      exp_w.push_back({ma, wd});
      ref_mem[a] = wd;
    end
    i_membus_ma = ma;
    i_membus_rd_rq = rd;
    i_membus_wr_rq = wr;
    i_membus_rq_cyc = 1'b1;
    i_membus_wr_rs = live && !wr;
    i_membus_mb_in = 36'({$urandom(), $urandom()});
    @(negedge clk);
    i_membus_wr_rs = 1'b0;
    if (!live) begin
      repeat (8) begin
        chk("no_response", {o_membus_addr_ack, o_read, o_write}, 0);
        @(negedge clk);
      end
    end else begin
      wait_out(0, "addr_ack");
      if (wr) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        if (!abort) begin
          i_membus_wr_rs = 1'b1;
          i_membus_mb_in = wd;
          @(negedge clk);
          i_membus_wr_rs = 1'b0;
          wait_out(1, "write_handshake");
          @(negedge clk);
        end
      end
    end
    drop_rq();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit saw;
    logic [17:0] ma;
    logic [35:0] wd;
    int k;
    for (int i = 0; i < WORDS; i++) begin
      slave_mem[i] = 36'(i * 7919 + 123);
      ref_mem[i] = 36'(i * 7919 + 123);
    end
    #1;
    chk("reset_outputs", {o_membus_addr_ack, o_membus_rd_rs, o_membus_mb_out, o_address, o_read, o_write, o_writedata, o_timeout}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // directed read latency with a one-wait slave
    mode = 1;
    slave_mem[64] = 36'o123456701234;
    ref_mem[64] = 36'o123456701234;
    exp_raddr.push_back(18'o000100);
    exp_rdata.push_back(36'o123456701234);
    i_membus_ma = 18'o000100;
    i_membus_rd_rq = 1'b1;
    i_membus_rq_cyc = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("rd_lat_read_%0d", c), o_read, c < 3);
      chk($sformatf("rd_lat_ack_%0d", c), o_membus_addr_ack, c == 3);
      chk($sformatf("rd_lat_rs_%0d", c), o_membus_rd_rs, c == 3);
    end
    chk("rd_address", o_address, 18'o000100);
    chk("rd_mb_out", o_membus_mb_out, 36'o123456701234);
    drop_rq();

    // directed write latency
    exp_w.push_back({18'o037777, 36'o777777777777});
    ref_mem[16383] = 36'o777777777777;
    i_membus_ma = 18'o037777;
    i_membus_wr_rq = 1'b1;
    i_membus_rq_cyc = 1'b1;
    @(negedge clk);
    chk("wr_ack_at_1", o_membus_addr_ack, 1);
    @(negedge clk);
    chk("wr_wait_quiet", {o_membus_addr_ack, o_write}, 0);
    i_membus_wr_rs = 1'b1;
    i_membus_mb_in = 36'o777777777777;
    @(negedge clk);
    i_membus_wr_rs = 1'b0;
    chk("wr_write_after_rs", o_write, 1);
    chk("wr_writedata", o_writedata, 36'o777777777777);
    repeat (2) @(negedge clk);
    repeat (4) begin
      chk("wr_done_quiet", {o_membus_addr_ack, o_read, o_write}, 0);
      @(negedge clk);
    end
    drop_rq();

    // read-modify-write and out-of-range
    mode = 0;
    run(1, 1, 18'o000005, 36'o525252525252, 0);
    run(1, 0, 18'o040000, 36'o0, 0);
    run(0, 1, 18'o040000, 36'o1, 0);

    // randomized mix
    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 5);
      ma = ($urandom_range(0, 7) == 0) ? 18'd16383 : 18'($urandom_range(0, 15));
      wd = 36'({$urandom(), $urandom()});
      if (k == 0) run(1, 0, ma, wd, 0);
      else if (k == 1) run(0, 1, ma, wd, 0);
      else if (k == 2) run(1, 1, ma, wd, 0);
      else if (k == 3) run(0, 0, ma, wd, 0);
      else if (k == 4) run(1'($urandom_range(0, 1)), 1, 18'(WORDS + $urandom_range(0, 1000)), wd, 0);
      else run(0, 1, ma, wd, 1);
    end

    // timeout on a stuck read
    mode = 2;
    chk("timeout_clear_before", o_timeout, 0);
    i_membus_ma = 18'd3;
    i_membus_rd_rq = 1'b1;
    i_membus_rq_cyc = 1'b1;
    @(negedge clk);
    n = 0;
    saw = 0;
    while (o_read && n < 400) begin
      n++;
      saw |= o_membus_rd_rs | o_membus_addr_ack;
      @(negedge clk);
    end
    chk("timeout_read_cycles", n, 255);
    chk("timeout_flag", o_timeout, 1);
    repeat (3) begin
      saw |= o_membus_rd_rs | o_membus_addr_ack | o_read;
      @(negedge clk);
    end
    chk("timeout_no_pulses", saw, 0);
    drop_rq();

    // async reset in the middle of a stuck write
    i_membus_ma = 18'd7;
    i_membus_wr_rq = 1'b1;
    i_membus_rq_cyc = 1'b1;
    repeat (2) @(negedge clk);
    i_membus_wr_rs = 1'b1;
    i_membus_mb_in = 36'o111111111111;
    @(negedge clk);
    i_membus_wr_rs = 1'b0;
    chk("rst_write_active", o_write, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_outputs", {o_membus_addr_ack, o_membus_rd_rs, o_membus_mb_out, o_address, o_read, o_write, o_writedata, o_timeout}, 0);
    i_membus_rq_cyc = 1'b0;
    i_membus_wr_rq = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mode = 0;
    @(negedge clk);
    run(1, 0, 18'd7, 36'o0, 0);
    chk("rst_timeout_stays_clear", o_timeout, 0);

    repeat (4) @(negedge clk);
    chk("read_queue_drained", exp_raddr.size(), 0);
    chk("rdata_queue_drained", exp_rdata.size(), 0);
    chk("write_queue_drained", exp_w.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
